aes_axi_wrapper: RTL and testbench

AES_AXI_WRAPPER -- requirements
Module: aes_axi_wrapper

---
 rtl/aes_pkg.sv | 91 +++++++++
 rtl/aes_enc_core.sv | 67 ++++++
 rtl/aes_axi_wrapper.sv | 175 +++++++++++++++++
 tb/tb_aes_axi_wrapper.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 helpers for the AXI wrapper: register offsets, S-box,
// GF(2^8) arithmetic, MixColumns and the round constants.
package aes_pkg;

  localparam logic [5:0] ADDR_PT0    = 6'h00;
  localparam logic [5:0] ADDR_PT3    = 6'h0C;
  localparam logic [5:0] ADDR_K0     = 6'h10;
  localparam logic [5:0] ADDR_CT0    = 6'h20;
  localparam logic [5:0] ADDR_STATUS = 6'h30;

  // Registers are decoded on the word address; bits [3:2] of it select a bank.
  localparam logic [3:0] WORD_PT3    = ADDR_PT3[5:2];
  localparam logic [3:0] WORD_STATUS = ADDR_STATUS[5:2];
  localparam logic [1:0] BANK_PT     = ADDR_PT0[5:4];
  localparam logic [1:0] BANK_K      = ADDR_K0[5:4];
  localparam logic [1:0] BANK_CT     = ADDR_CT0[5:4];

  localparam logic [3:0] LAST_ROUND  = 4'd10;

  typedef enum logic {ST_IDLE, ST_RUN} ctrl_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h01;
    p   = x;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_enc_core.sv
// Iterative AES-128 encryption datapath: one round per cycle with the key
// schedule expanded on the fly. Round 0 is the initial AddRoundKey.
module aes_enc_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [3:0]   round,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic [127:0] state_next
);

  logic [127:0] state_q;
  logic [127:0] rk_q;
  logic [127:0] rk_next;
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [31:0]  w0, w1, w2, w3, tmp, n0, n1, n2, n3;

  // Byte i of the state sits at [127-8*i -: 8]; columns are 4 consecutive bytes.
  always_comb begin
    {w0, w1, w2, w3} = rk_q;
    tmp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round), 24'h000000};
    n0  = w0 ^ tmp;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    rk_next = (round == 4'd0) ? rk_q : {n0, n1, n2, n3};

    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      sb[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end

    if (round == 4'd0) state_next = state_q ^ rk_q;
    else if (round == LAST_ROUND) state_next = sr ^ rk_next;
    else state_next = mc ^ rk_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      rk_q    <= '0;
    end else if (load) begin
      state_q <= pt;
      rk_q    <= key;
    end else if (en) begin
      state_q <= state_next;
      rk_q    <= rk_next;
    end
  end

endmodule

// File: rtl/aes_axi_wrapper.sv
// AXI4-Lite register front end for the AES-128 encryption core.
// Optional macro AES_KEY_READBACK_EN makes PT/K registers readable.
module aes_axi_wrapper
  import aes_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [5:0]  S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [5:0]  S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are
  // both high; READY pulses are registered, VALID outputs hold until accepted.
  ctrl_state_t  state_q, state_d;
  logic [3:0]   round_q;
  logic [31:0]  pt_q [4];
  logic [31:0]  key_q [4];
  logic [31:0]  ct_q [4];
  logic [31:0]  pt_d [4];
  logic [31:0]  key_d [4];
  logic         done_q, busy, start, last;
  logic [127:0] core_next;

  logic         aw_held_q, rd_pend_q, wr_fire, ar_fire, rd_stall;
  logic [3:0]   aw_word_q, ar_word_q, rd_sel;
  logic [31:0]  rd_word;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign wr_fire = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
  assign busy    = (state_q == ST_RUN);

  always_comb begin
    pt_d  = pt_q;
    key_d = key_q;
    if (wr_fire && aw_word_q[3:2] == BANK_PT)
      pt_d[aw_word_q[1:0]] = apply_strb(pt_q[aw_word_q[1:0]], S_AXI_WDATA, S_AXI_WSTRB);
    if (wr_fire && aw_word_q[3:2] == BANK_K)
      key_d[aw_word_q[1:0]] = apply_strb(key_q[aw_word_q[1:0]], S_AXI_WDATA, S_AXI_WSTRB);
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: if (wr_fire && aw_word_q == WORD_PT3) begin
        state_d = ST_RUN;
        start   = 1'b1;
      end
      ST_RUN: if (round_q == LAST_ROUND) begin
        state_d = ST_IDLE;
        last    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The core loads the post-write register values so the PT3 write that
  // starts a run is part of the plaintext.
  aes_enc_core u_core (
    .clk        (ACLK),
    .rst        (ARESETN),
    .load       (start),
    .en         (busy),
    .round      (round_q),
    .pt         ({pt_d[0], pt_d[1], pt_d[2], pt_d[3]}),
    .key        ({key_d[0], key_d[1], key_d[2], key_d[3]}),
    .state_next (core_next)
  );

  always_ff @(posedge ACLK) begin
    if (ARESETN) begin
      state_q <= ST_IDLE;
      round_q <= 4'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pt_q[i]  <= '0;
        key_q[i] <= '0;
        ct_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      if (start) round_q <= 4'd0;
      else if (busy) round_q <= round_q + 4'd1;
      if (start) begin
        done_q <= 1'b0;
      end else if (last) begin
        done_q <= 1'b1;
        for (int i = 0; i < 4; i++) ct_q[i] <= core_next[127-32*i -: 32];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      aw_held_q     <= 1'b0;
      aw_word_q     <= '0;
    end else begin
      S_AXI_AWREADY <= S_AXI_AWVALID && !S_AXI_AWREADY && !aw_held_q && !S_AXI_BVALID;
      S_AXI_WREADY  <= S_AXI_WVALID && aw_held_q && !S_AXI_WREADY;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_held_q <= 1'b1;
        aw_word_q <= S_AXI_AWADDR[5:2];
      end
      if (wr_fire) begin
        aw_held_q    <= 1'b0;
        S_AXI_BVALID <= 1'b1;
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // A pending read re-evaluates its stall each cycle; CT reads wait out RUN.
  always_comb begin
    rd_sel   = rd_pend_q ? ar_word_q : S_AXI_ARADDR[5:2];
    rd_stall = (rd_sel[3:2] == BANK_CT) && busy;
    rd_word  = '0;
    case (rd_sel[3:2])
`ifdef AES_KEY_READBACK_EN
      BANK_PT: rd_word = pt_q[rd_sel[1:0]];
      BANK_K:  rd_word = key_q[rd_sel[1:0]];
`endif
      BANK_CT: rd_word = ct_q[rd_sel[1:0]];
      default: if (rd_sel == WORD_STATUS) rd_word = {30'd0, busy, done_q};
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      rd_pend_q     <= 1'b0;
      ar_word_q     <= '0;
    end else begin
      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_ARREADY && !rd_pend_q && !S_AXI_RVALID;
      if (ar_fire && rd_stall) begin
        rd_pend_q <= 1'b1;
        ar_word_q <= S_AXI_ARADDR[5:2];
      end else if ((ar_fire || rd_pend_q) && !rd_stall) begin
        rd_pend_q    <= 1'b0;
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_axi_wrapper.sv
// Directed bench for aes_axi_wrapper: register table vectors plus hand-built
// sequences for stalled reads, BUSY timing, back-pressure and mid-run reset.
module tb_aes_axi_wrapper;

`ifdef AES_KEY_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [5:0]  S_AXI_AWADDR;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic [5:0]  S_AXI_ARADDR;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID, S_AXI_RREADY;

  aes_axi_wrapper dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 ACLK = ~ACLK;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  function automatic void vw(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.data = d; v.strb = s; v.exp = '0; v.name = "wr";
    vecs.push_back(v);
  endfunction

  function automatic void vr(input logic [5:0] a, input logic [31:0] e, input string nm);
    vec_t v;
    v.wr = 1'b0; v.addr = a; v.data = '0; v.strb = '0; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge ACLK); #1;
  endtask

  function automatic logic sig(input int ch);
    case (ch)
      0: return S_AXI_AWREADY;
      1: return S_AXI_WREADY;
      2: return S_AXI_BVALID;
      3: return S_AXI_ARREADY;
      default: return S_AXI_RVALID;
    endcase
  endfunction

  task automatic wait_high(input int ch, input string nm);
    int n = 0;
    while (!sig(ch) && n < 40) begin step(); n++; end
    if (!sig(ch)) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: timeout after %0d cycles, required 1", nm, n);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int w_cyc);
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    wait_high(0, "awready_wait");
    step(); S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    wait_high(1, "wready_wait");
    step(); S_AXI_WVALID = 1'b0; w_cyc = cyc;
    S_AXI_BREADY = 1'b1;
    wait_high(2, "bvalid_wait");
    step(); S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                          output int ar_cyc, output int r_cyc);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    wait_high(3, "arready_wait");
    step(); S_AXI_ARVALID = 1'b0; ar_cyc = cyc;
    wait_high(4, "rvalid_wait");
    r_cyc = cyc; d = S_AXI_RDATA;
    S_AXI_RREADY = 1'b1;
    step(); S_AXI_RREADY = 1'b0;
  endtask

  task automatic run_vecs();
    logic [31:0] d;
    int t0, t1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, t0);
      else begin
        axi_read(vecs[i].addr, d, t0, t1);
        check(vecs[i].name, d, vecs[i].exp);
      end
    end
    vecs.delete();
  endtask

  // STATUS expected for a read accepted on edge k of a run started on edge e0.
  function automatic logic [31:0] status_model(input int k, input int e0);
    if (k >= e0 + 12) return 32'h1;
    if (k > e0) return 32'h2;
    return 32'h0;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [31:0] d;
    int e0, ak, rk, t, g;

    ARESETN = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    repeat (3) step();
    ARESETN = 1'b0;
    check("reset_handshakes", {27'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                               S_AXI_ARREADY, S_AXI_RVALID}, 32'h0);
    check("reset_rdata", S_AXI_RDATA, 32'h0);
    check("resp_okay", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'h0);

    // Reset values, key/plaintext load, read-only and unmapped addresses.
    vr(6'h30, 32'h0, "status_rst");
    vr(6'h20, 32'h0, "ct0_rst");
    vr(6'h2C, 32'h0, "ct3_rst");
    vr(6'h10, 32'h0, "k0_rst");
    vw(6'h10, 32'h00010203, 4'hF);
    vw(6'h14, 32'h04050607, 4'hF);
    vw(6'h18, 32'h08090a0b, 4'hF);
    vw(6'h1C, 32'h0c0d0e0f, 4'hF);
    vw(6'h00, 32'h00112233, 4'hF);
    vw(6'h04, 32'h44556677, 4'hF);
    vw(6'h08, 32'h8899aabb, 4'hF);
    vw(6'h20, 32'hdeadbeef, 4'hF);
    vw(6'h38, 32'h12345678, 4'hF);
    vr(6'h18, RB ? 32'h08090a0b : 32'h0, "k2_readback");
    vr(6'h04, RB ? 32'h44556677 : 32'h0, "pt1_readback");
    vr(6'h20, 32'h0, "ct0_read_only");
    vr(6'h38, 32'h0, "unmapped_read");
    vr(6'h30, 32'h0, "status_idle");
    run_vecs();

    // Start and immediately read CT0: data only after DONE.
    axi_write(6'h0C, 32'hccddeeff, 4'hF, e0);
    axi_read(6'h20, d, ak, rk);
    check("stall_ct0_data", d, 32'h69c4e0d8);
    check("stall_rvalid_cycle", rk - e0, 32'd12);

    vr(6'h20, 32'h69c4e0d8, "ct0");
    vr(6'h24, 32'h6a7b0430, "ct1");
    vr(6'h28, 32'hd8cdb780, "ct2");
    vr(6'h2C, 32'h70b4c55a, "ct3");
    vr(6'h30, 32'h1, "status_done");
    vr(6'h0C, RB ? 32'hccddeeff : 32'h0, "pt3_readback");
    run_vecs();

    // Back-to-back STATUS polling from several phase offsets around a run.
    for (int off = 0; off < 3; off++) begin
      axi_write(6'h0C, 32'hccddeeff, 4'hF, e0);
      repeat (off) step();
      g = 0;
      ak = e0;
      while (ak < e0 + 13 && g < 20) begin
        axi_read(6'h30, d, ak, rk);
        check("status_poll", d, status_model(ak, e0));
        g++;
      end
    end
    axi_read(6'h20, d, ak, rk);
    check("ct0_after_poll", d, 32'h69c4e0d8);

    // Writes during RUN: PT changes and a PT3 rewrite must not disturb the run.
    axi_write(6'h0C, 32'hccddeeff, 4'hF, e0);
    axi_write(6'h00, 32'h00000000, 4'hF, t);
    axi_write(6'h0C, 32'hccddeeff, 4'hF, t);
    axi_read(6'h30, d, ak, rk);
    check("status_no_restart", d, status_model(ak, e0));
    axi_read(6'h20, d, ak, rk);
    check("ct0_unaffected", d, 32'h69c4e0d8);
    axi_read(6'h00, d, ak, rk);
    check("pt0_updated_in_run", d, 32'h0);

    // AW then W five cycles later; B back-pressure blocks the next AW.
    S_AXI_AWADDR = 6'h14; S_AXI_AWVALID = 1'b1;
    wait_high(0, "aw1_wait");
    step();
    for (int i = 0; i < 5; i++) begin
      check("awready_while_held", {31'd0, S_AXI_AWREADY}, 32'h0);
      step();
    end
    S_AXI_WDATA = 32'ha5a5a5a5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    wait_high(1, "w1_wait");
    step(); S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bvalid_held", {31'd0, S_AXI_BVALID}, 32'h1);
      check("awready_during_b", {31'd0, S_AXI_AWREADY}, 32'h0);
      step();
    end
    S_AXI_BREADY = 1'b1;
    step(); S_AXI_BREADY = 1'b0;
    check("bvalid_cleared", {31'd0, S_AXI_BVALID}, 32'h0);
    wait_high(0, "aw2_wait");
    check("aw2_accepted", {31'd0, S_AXI_AWREADY}, 32'h1);
    step(); S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'h5a5a0000; S_AXI_WVALID = 1'b1;
    wait_high(1, "w2_wait");
    step(); S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    wait_high(2, "b2_wait");
    step(); S_AXI_BREADY = 1'b0;
    axi_read(6'h14, d, ak, rk);
    check("k1_second_write", d, RB ? 32'h5a5a0000 : 32'h0);

    // Reset five cycles into a run: everything cleared, no CT update later.
    axi_write(6'h0C, 32'hccddeeff, 4'hF, e0);
    while (cyc < e0 + 4) step();
    ARESETN = 1'b1;
    step();
    ARESETN = 1'b0;
    check("midrun_reset_handshakes", {27'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                                      S_AXI_ARREADY, S_AXI_RVALID}, 32'h0);
    vr(6'h30, 32'h0, "status_after_abort");
    vr(6'h20, 32'h0, "ct0_after_abort");
    vr(6'h2C, 32'h0, "ct3_after_abort");
    vr(6'h0C, 32'h0, "pt3_after_abort");
    run_vecs();
    repeat (15) step();
    vr(6'h30, 32'h0, "status_stays_idle");
    vr(6'h24, 32'h0, "ct1_stays_zero");
    // Byte strobes and ignored low address bits.
    vw(6'h10, 32'hffffffff, 4'b0011);
    vr(6'h10, RB ? 32'h0000ffff : 32'h0, "k0_strb_low");
    vw(6'h10, 32'h12345678, 4'b1100);
    vr(6'h10, RB ? 32'h1234ffff : 32'h0, "k0_strb_high");
    vw(6'h13, 32'haabbccdd, 4'b0100);
    vr(6'h12, RB ? 32'h12bbffff : 32'h0, "k0_strb_unaligned");
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
